// File: rtl/instr_fetch.sv
// Instruction fetch unit: four-state fetch/wait/issue sequencer with a
// single outstanding memory read, valid/ready issue handshake and branch redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic        imemEn,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        brTaken,
  input  logic [31:0] brTarget,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic [31:0] instrCount
);

  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & PC_ALIGN_MASK;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    ISSUE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    count_d    = count_q;
    imemEn     = 1'b0;
    instrValid = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (!stall) begin
          imemEn  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Read data arrives exactly one cycle after the strobe; stall cannot hold it.
        instr_d = imemData;
        state_d = ISSUE;
      end
      ISSUE: begin
        instrValid = 1'b1;
        if (instrReady) begin
          pc_d    = brTaken ? (brTarget & PC_ALIGN_MASK) : pc_plus4;
          count_d = count_q + 32'd1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= 32'd0;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      count_q <= count_d;
    end
  end

  assign imemAddr   = pc_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[31:26];
  assign pc         = pc_q;
  assign pcPlus4    = pc_plus4;
  assign instrCount = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: table of issue transactions plus hand-written
// sequences for reset, first fetch latency, stall hold and reset during WAIT.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        imemEn;
  logic [31:0] imemAddr;
  logic [31:0] imemData;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instrValid;
  logic        instrReady;
  logic        brTaken;
  logic [31:0] brTarget;
  logic [31:0] pc;
  logic [31:0] pcPlus4;
  logic [31:0] instrCount;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_count;

  // Low bits set on purpose: the DUT must align them away.
  instr_fetch #(.RESET_PC(32'h00000003)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imemEn(imemEn), .imemAddr(imemAddr), .imemData(imemData),
    .instr(instr), .opcode(opcode), .instrValid(instrValid),
    .instrReady(instrReady), .brTaken(brTaken), .brTarget(brTarget),
    .pc(pc), .pcPlus4(pcPlus4), .instrCount(instrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: opcode chosen by word index, low 26 bits echo the address.
  logic [5:0] op_tab [16];
  initial begin
    op_tab[0]  = 6'b010000; op_tab[1]  = 6'b000000; op_tab[2]  = 6'b000001;
    op_tab[3]  = 6'b110010; op_tab[4]  = 6'b110001; op_tab[5]  = 6'b100000;
    op_tab[6]  = 6'b100001; op_tab[7]  = 6'b100010; op_tab[8]  = 6'b100011;
    op_tab[9]  = 6'b100100; op_tab[10] = 6'b100101; op_tab[11] = 6'b100110;
    op_tab[12] = 6'b100111; op_tab[13] = 6'b001000; op_tab[14] = 6'b001001;
    op_tab[15] = 6'b001010;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {op_tab[a[5:2]], a[25:0]};
  endfunction

  always @(posedge clk) begin
    if (imemEn) imemData <= mem_word(imemAddr);
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got no summary, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          delay;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] exp_pc;
    logic [5:0]  exp_op;
    logic [31:0] exp_next;
  } txn_t;

  txn_t tab [15];

  initial begin
    tab[0]  = '{0, 1'b0, 32'h0,        32'h00000004, 6'b000000, 32'h00000008};
    tab[1]  = '{5, 1'b0, 32'h0,        32'h00000008, 6'b000001, 32'h0000000C};
    tab[2]  = '{1, 1'b0, 32'h0,        32'h0000000C, 6'b110010, 32'h00000010};
    tab[3]  = '{0, 1'b0, 32'h0,        32'h00000010, 6'b110001, 32'h00000014};
    tab[4]  = '{2, 1'b0, 32'h0,        32'h00000014, 6'b100000, 32'h00000018};
    tab[5]  = '{0, 1'b0, 32'h0,        32'h00000018, 6'b100001, 32'h0000001C};
    tab[6]  = '{0, 1'b0, 32'h0,        32'h0000001C, 6'b100010, 32'h00000020};
    tab[7]  = '{3, 1'b0, 32'h0,        32'h00000020, 6'b100011, 32'h00000024};
    tab[8]  = '{0, 1'b0, 32'h0,        32'h00000024, 6'b100100, 32'h00000028};
    tab[9]  = '{0, 1'b0, 32'h0,        32'h00000028, 6'b100101, 32'h0000002C};
    tab[10] = '{0, 1'b0, 32'h0,        32'h0000002C, 6'b100110, 32'h00000030};
    tab[11] = '{0, 1'b1, 32'h00000103, 32'h00000030, 6'b100111, 32'h00000100};
    tab[12] = '{1, 1'b1, 32'hFFFFFFFE, 32'h00000100, 6'b010000, 32'hFFFFFFFC};
    tab[13] = '{0, 1'b0, 32'h0,        32'hFFFFFFFC, 6'b001010, 32'h00000000};
    tab[14] = '{0, 1'b0, 32'h0,        32'h00000000, 6'b010000, 32'h00000004};

    rst = 1'b0; stall = 1'b0; instrReady = 1'b1; brTaken = 1'b0; brTarget = 32'h0;
    #2;
    chk("rst_valid",   {31'd0, instrValid}, 32'd0);
    chk("rst_en",      {31'd0, imemEn},     32'd0);
    chk("rst_addr",    imemAddr,            32'h0);
    chk("rst_instr",   instr,               32'h0);
    chk("rst_opcode",  {26'd0, opcode},     32'h0);
    chk("rst_pcplus4", pcPlus4,             32'h4);
    chk("rst_count",   instrCount,          32'h0);

    // First fetch after release: IDLE, FETCH(addr 0), WAIT, ISSUE.
    tick();
    rst = 1'b1;
    #1;
    chk("c0_en", {31'd0, imemEn}, 32'd0);
    tick();
    chk("c1_en",   {31'd0, imemEn}, 32'd1);
    chk("c1_addr", imemAddr,        32'h0);
    tick();
    chk("c2_en",    {31'd0, imemEn},     32'd0);
    chk("c2_valid", {31'd0, instrValid}, 32'd0);
    tick();
    chk("c3_valid",  {31'd0, instrValid}, 32'd1);
    chk("c3_opcode", {26'd0, opcode},     32'h10);
    chk("c3_instr",  instr,               32'h40000000);
    chk("c3_pc",     pc,                  32'h0);
    tick();
    chk("c4_addr",  imemAddr,        32'h4);
    chk("c4_count", instrCount,      32'h1);
    exp_count = 32'd1;

    for (int i = 0; i < 15; i++) begin
      // FETCH: branch inputs are junk here and must be ignored.
      instrReady = 1'b1; stall = 1'b0; brTaken = 1'b1; brTarget = 32'hDEADBEE0;
      #1;
      chk($sformatf("t%0d_fetch_en", i),    {31'd0, imemEn},     32'd1);
      chk($sformatf("t%0d_fetch_addr", i),  imemAddr,            tab[i].exp_pc);
      chk($sformatf("t%0d_fetch_valid", i), {31'd0, instrValid}, 32'd0);
      tick();
      chk($sformatf("t%0d_wait_valid", i), {31'd0, instrValid}, 32'd0);
      tick();
      chk($sformatf("t%0d_valid", i),   {31'd0, instrValid}, 32'd1);
      chk($sformatf("t%0d_pc", i),      pc,                  tab[i].exp_pc);
      chk($sformatf("t%0d_opcode", i),  {26'd0, opcode},     {26'd0, tab[i].exp_op});
      chk($sformatf("t%0d_instr", i),   instr,               mem_word(tab[i].exp_pc));
      chk($sformatf("t%0d_pcplus4", i), pcPlus4,             tab[i].exp_pc + 32'd4);
      for (int d = 0; d < tab[i].delay; d++) begin
        instrReady = 1'b0; stall = 1'b1; brTaken = 1'b1; brTarget = 32'h00000800;
        #1;
        chk($sformatf("t%0d_hold%0d_valid", i, d), {31'd0, instrValid}, 32'd1);
        chk($sformatf("t%0d_hold%0d_instr", i, d), instr,      mem_word(tab[i].exp_pc));
        chk($sformatf("t%0d_hold%0d_pc", i, d),    pc,         tab[i].exp_pc);
        chk($sformatf("t%0d_hold%0d_count", i, d), instrCount, exp_count);
        tick();
      end
      instrReady = 1'b1; stall = 1'b0; brTaken = tab[i].br_taken; brTarget = tab[i].br_target;
      tick();
      exp_count = exp_count + 32'd1;
      $display("txn %0d: pc=%h opcode=%b next=%h count=%0d", i, tab[i].exp_pc, tab[i].exp_op,
               imemAddr, instrCount);
      chk($sformatf("t%0d_next_addr", i), imemAddr,   tab[i].exp_next);
      chk($sformatf("t%0d_count", i),     instrCount, exp_count);
    end

    // Stall held four cycles in FETCH at pc 4.
    brTaken = 1'b0; brTarget = 32'h0; stall = 1'b1;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk($sformatf("stall%0d_en", s),   {31'd0, imemEn}, 32'd0);
      chk($sformatf("stall%0d_addr", s), imemAddr,        32'h4);
      tick();
      stall = 1'b1;
    end
    stall = 1'b0;
    #1;
    chk("unstall_en",   {31'd0, imemEn}, 32'd1);
    chk("unstall_addr", imemAddr,        32'h4);
    tick();
    tick();
    chk("stall_issue_pc", pc, 32'h4);
    tick();
    exp_count = exp_count + 32'd1;
    chk("stall_count", instrCount, exp_count);
    chk("stall_next",  imemAddr,   32'h8);
    $display("stall txn: pc=00000004 count=%0d", instrCount);

    // Reset while in WAIT abandons the pending instruction.
    tick();
    rst = 1'b0;
    #1;
    chk("wrst_valid", {31'd0, instrValid}, 32'd0);
    chk("wrst_en",    {31'd0, imemEn},     32'd0);
    chk("wrst_count", instrCount,          32'd0);
    chk("wrst_addr",  imemAddr,            32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("wrel_en", {31'd0, imemEn}, 32'd0);
    tick();
    chk("wrel_fetch_en",   {31'd0, imemEn}, 32'd1);
    chk("wrel_fetch_addr", imemAddr,        32'h0);
    tick();
    tick();
    chk("wrel_instr", instr,      32'h40000000);
    chk("wrel_count", instrCount, 32'd0);
    $display("reset-in-wait txn: refetch pc=%h instr=%h", pc, instr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
